// File: rtl/param_icache.sv
`timescale 1ns/1ps
// Direct-mapped instruction cache with word-serial line refill; define ICACHE_PERF_CNT_EN for hit/miss counters.
// Latency: hit answered 1 cycle after acceptance; miss refills LINE_WORDS words (one outstanding), then RESPOND.
// Backpressure: req_ready drops while a miss or flush is in progress; mem_req_valid holds its address until mem_req_ready.
module param_icache #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int SETS       = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    output logic [31:0]       resp_instr,
    output logic              stall,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int WA_W  = ADDR_W - 2;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LOOKUP      = 3'd1;
    localparam logic [2:0] S_REFILL_REQ  = 3'd2;
    localparam logic [2:0] S_REFILL_WAIT = 3'd3;
    localparam logic [2:0] S_RESPOND     = 3'd4;
    localparam logic [2:0] S_FLUSH       = 3'd5;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    logic [2:0]       state_q, state_d;
    logic [WA_W-1:0]  waddr_q, waddr_d;
    logic [OFF_W-1:0] word_q, word_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic             flush_pend_q, flush_pend_d;

    logic [31:0]      data_q [SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_q  [SETS];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [31:0]      rd_word;
    logic             line_wr;
    logic             flush_go;
    logic             addr_lsb_unused;

    // Byte-lane bits never reach the cache; only the word address is registered.
    assign addr_lsb_unused = ^req_addr[1:0];

    assign off     = waddr_q[OFF_W-1:0];
    assign idx     = waddr_q[OFF_W+IDX_W-1:OFF_W];
    assign tag     = waddr_q[WA_W-1:OFF_W+IDX_W];
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign rd_word = data_q[{idx, off}];
    assign flush_go = flush || flush_pend_q;

    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_instr    = '0;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = !flush;
            end
            S_LOOKUP: begin
                resp_valid = hit;
                resp_instr = hit ? rd_word : '0;
                stall      = !hit;
                req_ready  = hit && !flush_go;
            end
            S_REFILL_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                // Word counter replaces the offset field, so it can never carry into index/tag.
                mem_req_addr  = {waddr_q[WA_W-1:OFF_W], word_q, 2'b00};
            end
            S_REFILL_WAIT: begin
                stall = 1'b1;
            end
            S_RESPOND: begin
                resp_valid = 1'b1;
                resp_instr = rd_word;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        word_d       = word_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        line_wr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (req_valid) begin
                    waddr_d = req_addr[ADDR_W-1:2];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    if (flush_go) begin
                        flush_pend_d = 1'b0;
                        state_d      = S_FLUSH;
                    end else if (req_valid) begin
                        waddr_d = req_addr[ADDR_W-1:2];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    // Drop the victim now so an abandoned refill never leaves a stale line valid.
                    valid_d[idx] = 1'b0;
                    word_d       = '0;
                    flush_pend_d = flush_go;
                    state_d      = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                flush_pend_d = flush_go;
                if (mem_req_ready) begin
                    state_d = S_REFILL_WAIT;
                end
            end
            S_REFILL_WAIT: begin
                flush_pend_d = flush_go;
                if (mem_resp_valid) begin
                    line_wr = 1'b1;
                    if (word_q == LAST_WORD) begin
                        valid_d[idx] = 1'b1;
                        state_d      = S_RESPOND;
                    end else begin
                        word_d  = word_q + OFF_W'(1);
                        state_d = S_REFILL_REQ;
                    end
                end
            end
            S_RESPOND: begin
                if (flush_go) begin
                    flush_pend_d = 1'b0;
                    state_d      = S_FLUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                valid_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            waddr_q      <= '0;
            word_q       <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            word_q       <= word_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_ff @(posedge clock) begin
        if (line_wr) begin
            data_q[{idx, word_q}] <= mem_resp_data;
            if (word_q == LAST_WORD) begin
                tag_q[idx] <= tag;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_LOOKUP) begin
            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_param_icache.sv
`timescale 1ns/1ps
// Directed bench for param_icache (LINE_WORDS=16, SETS=64); memory word at byte address A reads 0x1000_0000+A.
module tb_param_icache;
    logic        clock;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        stall;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int tests  = 0;
    int failed = 0;
    logic [31:0] req_log [$];

    param_icache #(.ADDR_W(32), .LINE_WORDS(16), .SETS(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .flush          (flush),
        .resp_valid     (resp_valid),
        .resp_instr     (resp_instr),
        .stall          (stall),
`ifdef ICACHE_PERF_CNT_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`endif
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Backing memory: logs each accepted request and answers one cycle later.
    initial begin : responder
        logic        fire;
        logic [31:0] a;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        forever begin
            @(negedge clock);
            fire = mem_req_valid && mem_req_ready;
            a    = mem_req_addr;
            if (fire) req_log.push_back(a);
            @(posedge clock);
            #1;
            mem_resp_valid = fire;
            mem_resp_data  = fire ? (32'h1000_0000 + a) : 32'h0;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic [31:0] a);
        mem_req_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            #2;
            check("hold_mem_req_valid", mem_req_valid, 1);
            check("hold_mem_req_addr", mem_req_addr, a);
            check("hold_stall", stall, 1);
            check("hold_resp_valid", resp_valid, 0);
        end
        mem_req_ready = 1'b1;
    endtask

    task automatic hit(input logic [31:0] addr);
        tick();
        req_valid = 1'b1;
        req_addr  = addr;
        #2;
        check("hit_accept_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        #2;
        check("hit_resp_valid", resp_valid, 1);
        check("hit_resp_instr", resp_instr, 32'h1000_0000 + (addr & 32'hFFFF_FFFC));
        check("hit_stall", stall, 0);
    endtask

    task automatic miss(input logic [31:0] addr, input int flush_at, input int hold_word);
        logic [31:0] base;
        logic [31:0] exp;
        logic        done;
        logic        stall_ok;
        base = addr & 32'hFFFF_FFC0;
        exp  = 32'h1000_0000 + (addr & 32'hFFFF_FFFC);
        req_log.delete();
        tick();
        req_valid = 1'b1;
        req_addr  = addr;
        #2;
        check("miss_accept_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        #2;
        check("miss_lookup_resp_valid", resp_valid, 0);
        check("miss_lookup_stall", stall, 1);
        done     = 1'b0;
        stall_ok = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            if (resp_valid) begin
                done = 1'b1;
            end else begin
                if (!stall) stall_ok = 1'b0;
                if (hold_word >= 0 && req_log.size() == hold_word && mem_req_valid)
                    hold(base + 32'(4 * hold_word));
                tick();
                flush = (i == flush_at);
                #2;
            end
        end
        flush = 1'b0;
        check("miss_refill_done", done, 1);
        check("miss_stall_during_refill", stall_ok, 1);
        check("miss_resp_instr", resp_instr, exp);
        check("miss_resp_stall", stall, 0);
        check("miss_req_count", req_log.size(), 16);
        for (int k = 0; k < 16 && k < req_log.size(); k++)
            check("miss_req_addr", req_log[k], base + 32'(4 * k));
        tick();
        #2;
        check("after_respond_ready", req_ready, (flush_at < 0) ? 1 : 0);
        if (flush_at >= 0) tick();
    endtask

    initial begin : stimulus
        logic done_r;
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = 32'h0;
        flush         = 1'b0;
        mem_req_ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_instr", resp_instr, 0);
        check("rst_stall", stall, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        tick();
        tick();
        reset = 1'b0;

        // Cold miss then hit in the filled line.
        miss(32'h0, -1, -1);
        hit(32'h4);

        // Back-to-back hits; byte bits of 0x0A are ignored.
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h0000_000A;
        #2;
        tick();
        req_addr = 32'h0000_003C;
        #2;
        check("b2b_resp_valid0", resp_valid, 1);
        check("b2b_resp_instr0", resp_instr, 32'h1000_0008);
        check("b2b_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        #2;
        check("b2b_resp_valid1", resp_valid, 1);
        check("b2b_resp_instr1", resp_instr, 32'h1000_003C);

        // Index conflict evicts, refetch misses again.
        miss(32'h1000, -1, -1);
        miss(32'h0, -1, -1);

        // Top-of-address-space line.
        miss(32'hFFFF_FFC4, -1, -1);
        hit(32'hFFFF_FFFC);

        // Flush beats a simultaneous request in IDLE.
        hit(32'h0);
        tick();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        #2;
        check("flush_idle_req_ready", req_ready, 0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        #2;
        check("flush_state_req_ready", req_ready, 0);
        check("flush_state_resp_valid", resp_valid, 0);
        tick();
        #2;
        check("flush_done_req_ready", req_ready, 1);
        miss(32'h0, -1, -1);

        // Flush during refill is deferred until the response, then clears the new line too.
        miss(32'h40, 3, -1);
        miss(32'h40, -1, -1);

        // Memory stalls on word 3 of a line-0 refill.
        miss(32'h0, -1, 3);

        // Reset in the middle of a refill.
        req_log.delete();
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h2000;
        #2;
        tick();
        req_valid = 1'b0;
        done_r    = 1'b0;
        for (int i = 0; i < 100 && !done_r; i++) begin
            tick();
            #2;
            if (mem_req_valid && mem_req_addr == 32'h2014) done_r = 1'b1;
        end
        check("rst_mid_reached_word5", done_r, 1);
        check("rst_mid_words_before", req_log.size(), 5);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_mem_req_valid", mem_req_valid, 0);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_req_ready", req_ready, 1);
        tick();
        tick();
        reset = 1'b0;
        miss(32'h0, -1, -1);
        hit(32'h4);

`ifdef ICACHE_PERF_CNT_EN
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        check("perf_rst_hits", hit_count, 0);
        check("perf_rst_misses", miss_count, 0);
        miss(32'h0, -1, -1);
        for (int a = 4; a < 64; a += 4) hit(32'(a));
        tick();
        #2;
        check("perf_miss_count", miss_count, 1);
        check("perf_hit_count", hit_count, 15);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/param_icache.md
PARAM_ICACHE -- requirements
Module: param_icache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter LINE_WORDS, default 16, 32-bit words per line (power of 2, >=2); OFF_W=log2(LINE_WORDS).
REQ-003 SHALL have parameter SETS, default 64, direct-mapped lines (power of 2); IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W-2.
REQ-004 SHALL have port clock  in  1  single clock; all state changes on posedge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  fetch request.
REQ-007 SHALL have port req_addr  in  ADDR_W  byte address; bits[1:0] ignored.
REQ-008 SHALL have port req_ready  out  1  request accepted when req_valid&req_ready.
REQ-009 SHALL have port flush  in  1  invalidate all lines.
REQ-010 SHALL have port resp_valid  out  1  one-cycle pulse, resp_instr valid.
REQ-011 SHALL have port resp_instr  out  32  fetched instruction.
REQ-012 SHALL have port stall  out  1  miss in progress.
REQ-013 SHALL have ports mem_req_valid out 1, mem_req_addr out ADDR_W, mem_req_ready in 1: word-read request handshake to backing memory.
REQ-014 SHALL have ports mem_resp_valid in 1, mem_resp_data in 32: read return, no backpressure.

Function
REQ-015 SHALL decompose the registered address: tag=[ADDR_W-1:IDX_W+OFF_W+2], index=[IDX_W+OFF_W+1:OFF_W+2], word offset=[OFF_W+1:2].
REQ-016 SHALL implement FSM IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND, FLUSH.
REQ-017 SHALL assert req_ready only in IDLE, and in LOOKUP on hit (back-to-back hits, one per cycle).
REQ-018 SHALL register an accepted address and enter LOOKUP; hit = valid[index] & tag match.
REQ-019 On hit, resp_valid=1 and resp_instr=data[index][offset] in the LOOKUP cycle (latency 1 cycle after acceptance).
REQ-020 On miss, SHALL enter REFILL_REQ with stall=1, resp_valid=0, req_ready=0, and clear valid[index] immediately.
REQ-021 Refill SHALL issue LINE_WORDS requests, addresses line_base+4*k for k=0..LINE_WORDS-1, one outstanding; mem_req_valid held with stable address until mem_req_ready; REFILL_WAIT until mem_resp_valid, word k written.
REQ-022 Line base SHALL zero the offset and byte bits; word increments SHALL never carry into index/tag (top-of-space line refills correctly).
REQ-023 After word LINE_WORDS-1, SHALL set valid and tag, enter RESPOND: resp_valid=1 with the requested word, stall=0, then IDLE.
REQ-024 mem_resp_valid outside REFILL_WAIT SHALL be ignored.
REQ-025 flush in IDLE SHALL take priority over simultaneous req_valid (not accepted), enter FLUSH, clear all valid bits in one cycle, return to IDLE.
REQ-026 flush during LOOKUP/REFILL_*/RESPOND SHALL be latched pending; the current request completes, then FLUSH executes before any new acceptance.

Reset
REQ-027 Reset SHALL asynchronously force IDLE, clear all valid bits and flush-pending, and drive req_ready=1, resp_valid=0, resp_instr=0, stall=0, mem_req_valid=0, mem_req_addr=0.
REQ-028 Reset mid-refill SHALL abandon the refill; no partial line becomes valid.
REQ-029 Data and tag arrays SHALL NOT require reset.

Configuration
REQ-030 With ICACHE_PERF_CNT_EN defined, SHALL add outputs hit_count and miss_count (32 bits, reset 0), incremented on LOOKUP hit/miss, saturating at 0xFFFFFFFF.
REQ-031 Without ICACHE_PERF_CNT_EN, SHALL omit those ports and counters; all other behaviour identical.

Verification (LINE_WORDS=16, SETS=64; memory word at address A = 0x1000_0000+A)
REQ-032 Cold fetch 0x0, mem_req_ready=1, response 1 cycle later -> 16 requests 0x00..0x3C in order, stall high throughout, resp_instr=0x1000_0000, then fetch 0x4 -> hit next cycle, 0x1000_0004.
REQ-033 Fetch 0x0, then 0x1000 (same index 0) -> miss, refill 0x1000..0x103C; refetch 0x0 -> miss again.
REQ-034 flush with req_valid for 0x0 in IDLE -> not accepted; next fetch 0x0 -> miss after a prior hit.
REQ-035 Reset asserted during refill word 5 -> mem_req_valid 0 immediately; after release fetch 0x0 -> refill restarts at 0x0.
REQ-036 mem_req_ready low 10 cycles on word 3 -> mem_req_addr stays 0x0C, stall stays 1, no resp_valid.
REQ-037 With ICACHE_PERF_CNT_EN, 0x0 then 0x4..0x3C -> miss_count=1, hit_count=15.
